rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
- Reset/run sequencer sitting directly after the clock/reset generator; owns system reset release order.
- Synchronises both DCM LOCKED flags and waits for stable lock. Releases memory-side reset, then CPU reset, then drives the CPU clock enable.
- Handles lock loss, soft reset and halt. Replaces the purely combinational crst derivation.

Parameters:
- LOCK_STABLE_CYCLES, 1024, consecutive cycles both locks must be high before release.
- MEM_LEAD_CYCLES, 16, cycles mrst deasserts before crst; also soft-reset pulse length.
- CNT_W, 16, internal counter width; must hold max(LOCK_STABLE_CYCLES, MEM_LEAD_CYCLES).
- SYNC_STAGES, 2, flops per lock synchroniser (min 2).

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- cclk_locked  in  1  CPU-clock DCM lock; asynchronous, synchronised internally.
- mclk_locked  in  1  memory-clock DCM lock; asynchronous, synchronised internally.
- soft_rst_req  in  1  one-cycle request for CPU-only reset.
- halt_req  in  1  level; stalls the CPU while high.
- mrst  out  1  INST_MEM/DATA_MEM reset, active-high.
- crst  out  1  CPU reset, active-high.
- cpu_ce  out  1  CPU clock enable.
- sys_ready  out  1  high only in RUN.
- lock_err  out  1  sticky; set on any lock loss after first release.
- lock_loss_cnt  out  8  saturating count of lock-loss events.

Behaviour:
- All outputs registered; one-cycle latency from state change to outputs.
- RST (sync, high): state=WAIT_LOCK, counter=0. Outputs: mrst=1, crst=1, cpu_ce=0, sys_ready=0, lock_err=0, lock_loss_cnt=0. RST mid-operation aborts any state identically.
- lock_ok = AND of both synchronised locks (SYNC_STAGES cycles of input latency).
- WAIT_LOCK: counter++ while lock_ok, else counter=0. When counter==LOCK_STABLE_CYCLES-1 with lock_ok, go to MEM_REL and clear counter.
- MEM_REL: mrst=0, crst=1. Counter runs; at MEM_LEAD_CYCLES-1 go to RUN.
- RUN: mrst=0, crst=0, sys_ready=1, cpu_ce=!halt_req.
- RUN + soft_rst_req: go to SOFT. crst=1 and cpu_ce=0 for MEM_LEAD_CYCLES cycles, mrst stays 0, then return to RUN.
- soft_rst_req outside RUN is ignored, including while in SOFT.
- lock_ok low in MEM_REL, RUN or SOFT: go to LOCK_LOST.
  - Next cycle: mrst=1, crst=1, cpu_ce=0, sys_ready=0.
  - lock_err set; lock_loss_cnt += 1, saturating at 255.
  - After one cycle in LOCK_LOST, go to WAIT_LOCK with counter=0.
- Lock loss during WAIT_LOCK only clears the counter; no error is counted.
- Priority per cycle: RST > lock loss > soft_rst_req > halt_req.
- Encoding: WAIT_LOCK, MEM_REL, RUN, SOFT, LOCK_LOST. Illegal state recovers to LOCK_LOST.
- Invariant: crst=0 implies mrst=0.

Optional Feature:
- Macro: CPU_STEP_EN.
- When defined, adds ports step_mode (in, 1) and step_btn (in, 1, asynchronous).
  - step_btn passes through a synchroniser and rising-edge detect.
  - In RUN with step_mode=1, cpu_ce is a single-cycle pulse per detected edge; halt_req still forces 0.
  - step_mode=0 gives normal behaviour.
- When undefined: ports absent, cpu_ce = !halt_req in RUN.

Decomposition:
- Shared include rst_seq_defs.vh holds:
  - state encoding localparams (3-bit);
  - default LOCK_STABLE_CYCLES and MEM_LEAD_CYCLES;
  - lock_loss_cnt width (8).
- One sub-module, sync_bit (SYNC_STAGES-deep flop chain, reset value 0). Instantiated per lock input, and for step_btn under CPU_STEP_EN.

Test Plan (LOCK_STABLE_CYCLES=8, MEM_LEAD_CYCLES=4, SYNC_STAGES=2):
- Power-up: RST high 3 cycles, then both locks high at cycle 0 -> mrst falls at cycle 11±1, crst and sys_ready rise/fall 4 cycles later, cpu_ce=1.
- Lock glitch: mclk_locked low 1 cycle at count 5 in WAIT_LOCK -> counter restarts; release delayed by 6 cycles; lock_err stays 0.
- Lock loss in RUN: cclk_locked low -> within 3 cycles mrst=crst=1, sys_ready=0, lock_err=1, lock_loss_cnt=1. Lock restored -> full re-release sequence.
- Soft reset: soft_rst_req pulse in RUN -> crst=1 for exactly 4 cycles, mrst held 0. A second pulse during SOFT is ignored.
- Simultaneous events: soft_rst_req and lock drop in the same cycle -> LOCK_LOST wins. halt_req=1 in RUN -> cpu_ce=0, sys_ready stays 1.
- Saturation/step: 300 lock-loss events -> lock_loss_cnt=255. With CPU_STEP_EN and step_mode=1, 3 step_btn edges -> exactly 3 single-cycle cpu_ce pulses.

Source files
------------

// File: rtl/rst_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl_pkg
// Shared definitions for the reset/run sequencer:
//   - state_e       : 3-bit sequencer state encoding
//   - DEF_*         : default lock-stable and memory-lead cycle counts
//   - LOSS_CNT_W    : width of the saturating lock-loss counter
//   - sat_inc()     : saturating increment for the lock-loss counter
// ----------------------------------------------------------------------------
package rst_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_MEM_REL   = 3'd1,
    ST_RUN       = 3'd2,
    ST_SOFT      = 3'd3,
    ST_LOCK_LOST = 3'd4
  } state_e;

  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_MEM_LEAD_CYCLES    = 16;
  localparam int LOSS_CNT_W             = 8;

  // Holds at all-ones instead of wrapping, so a storm of lock losses
  // never reads back as a small number.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    if (v == {LOSS_CNT_W{1'b1}}) begin
      return v;
    end
    return v + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// ----------------------------------------------------------------------------
// sync_bit
// Single-bit synchroniser: STAGES-deep flop chain clocked on clk, cleared to
// 0 by the synchronous active-high rst.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset (chain clears to 0)
//   d    in  asynchronous input
//   q    out synchronised output (STAGES cycles of latency)
// ----------------------------------------------------------------------------
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl
// Reset/run sequencer placed right after the clock/reset generator. It waits
// for both DCM locks to be stably high, releases the memory reset, then the
// CPU reset, then enables the CPU clock. Lock loss, soft reset and halt are
// handled here.
//
// Optional feature (macro CPU_STEP_EN): adds step_mode / step_btn so the CPU
// can be single-stepped in RUN, one cpu_ce pulse per step_btn rising edge.
//
// Ports:
//   CLK            in   clock, everything on the rising edge
//   RST            in   synchronous active-high reset
//   cclk_locked    in   CPU-clock DCM lock (asynchronous)
//   mclk_locked    in   memory-clock DCM lock (asynchronous)
//   soft_rst_req   in   one-cycle request for a CPU-only reset
//   halt_req       in   level, stalls the CPU while high
//   step_mode      in   (CPU_STEP_EN) single-step mode select
//   step_btn       in   (CPU_STEP_EN) asynchronous step button
//   mrst           out  memory reset, active-high
//   crst           out  CPU reset, active-high
//   cpu_ce         out  CPU clock enable
//   sys_ready      out  high only in RUN
//   lock_err       out  sticky lock-loss flag
//   lock_loss_cnt  out  saturating lock-loss event count
//   state_dbg      out  current sequencer state (state_e encoding)
//
// Request semantics: soft_rst_req is a single-cycle strobe with no ready
// return; it is acted on only in the cycle it is seen while in RUN, and is
// dropped in every other state.
// ----------------------------------------------------------------------------
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int MEM_LEAD_CYCLES    = DEF_MEM_LEAD_CYCLES,
  parameter int CNT_W              = 16,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cclk_locked,
  input  logic                  mclk_locked,
  input  logic                  soft_rst_req,
  input  logic                  halt_req,
`ifdef CPU_STEP_EN
  input  logic                  step_mode,
  input  logic                  step_btn,
`endif
  output logic                  mrst,
  output logic                  crst,
  output logic                  cpu_ce,
  output logic                  sys_ready,
  output logic                  lock_err,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]            state_dbg
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(MEM_LEAD_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Lock synchronisers
  // --------------------------------------------------------------------------
  logic cclk_lock_s;
  logic mclk_lock_s;
  logic lock_ok;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cclk (
    .clk (CLK),
    .rst (RST),
    .d   (cclk_locked),
    .q   (cclk_lock_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_mclk (
    .clk (CLK),
    .rst (RST),
    .d   (mclk_locked),
    .q   (mclk_lock_s)
  );

  assign lock_ok = cclk_lock_s & mclk_lock_s;

  // --------------------------------------------------------------------------
  // Single-step qualifier
  // --------------------------------------------------------------------------
  logic step_ok;

`ifdef CPU_STEP_EN
  logic step_s;
  logic step_prev;
  logic step_edge;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_step (
    .clk (CLK),
    .rst (RST),
    .d   (step_btn),
    .q   (step_s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      step_prev <= 1'b0;
    end else begin
      step_prev <= step_s;
    end
  end

  assign step_edge = step_s & ~step_prev;
  assign step_ok   = ~step_mode | step_edge;
`else
  assign step_ok = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  state_e           state;
  state_e           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             loss_evt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Priority inside each state: lock loss, then soft reset. RST sits above
  // both in the register process. halt_req only touches cpu_ce.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    loss_evt = 1'b0;
    case (state)
      ST_WAIT_LOCK: begin
        // Losing lock here just restarts the stability window; the system
        // was never released, so it is not an error.
        if (!lock_ok) begin
          cnt_d = '0;
        end else if (cnt == LOCK_LAST) begin
          state_d = ST_MEM_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_MEM_REL: begin
        if (!lock_ok) begin
          state_d  = ST_LOCK_LOST;
          cnt_d    = '0;
          loss_evt = 1'b1;
        end else if (cnt == LEAD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_ok) begin
          state_d  = ST_LOCK_LOST;
          loss_evt = 1'b1;
        end else if (soft_rst_req) begin
          state_d = ST_SOFT;
        end
      end
      ST_SOFT: begin
        // A fresh soft_rst_req here is ignored: the pulse length is fixed.
        if (!lock_ok) begin
          state_d  = ST_LOCK_LOST;
          cnt_d    = '0;
          loss_evt = 1'b1;
        end else if (cnt == LEAD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_LOCK_LOST: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
      default: begin
        // Corrupted state: force everything back into reset and start over.
        state_d = ST_LOCK_LOST;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so they change on the
  // same edge the state does. mrst is only low in the released states, and
  // crst is only low in RUN, so crst=0 always implies mrst=0.
  // --------------------------------------------------------------------------
  logic mem_released_d;
  logic run_d;

  assign mem_released_d = (state_d == ST_MEM_REL) || (state_d == ST_RUN) ||
                          (state_d == ST_SOFT);
  assign run_d          = (state_d == ST_RUN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      mrst          <= 1'b1;
      crst          <= 1'b1;
      cpu_ce        <= 1'b0;
      sys_ready     <= 1'b0;
      lock_err      <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      mrst      <= ~mem_released_d;
      crst      <= ~run_d;
      cpu_ce    <= run_d & ~halt_req & step_ok;
      sys_ready <= run_d;
      if (loss_evt) begin
        lock_err      <= 1'b1;
        lock_loss_cnt <= sat_inc(lock_loss_cnt);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rst_seq_ctrl
// Directed bench for rst_seq_ctrl with LOCK_STABLE_CYCLES=8,
// MEM_LEAD_CYCLES=4, SYNC_STAGES=2. Inputs are driven and outputs sampled
// 1 time unit after each rising edge; cyc counts edges since RST dropped.
// ----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       cclk_locked;
  logic       mclk_locked;
  logic       soft_rst_req;
  logic       halt_req;
`ifdef CPU_STEP_EN
  logic       step_mode;
  logic       step_btn;
`endif
  logic       mrst;
  logic       crst;
  logic       cpu_ce;
  logic       sys_ready;
  logic       lock_err;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_dbg;

  int n_checks;
  int n_pass;
  int cyc;

  logic [3:0] exp_q[$];

  rst_seq_ctrl #(
    .LOCK_STABLE_CYCLES (8),
    .MEM_LEAD_CYCLES    (4),
    .CNT_W              (16),
    .SYNC_STAGES        (2)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .cclk_locked   (cclk_locked),
    .mclk_locked   (mclk_locked),
    .soft_rst_req  (soft_rst_req),
    .halt_req      (halt_req),
`ifdef CPU_STEP_EN
    .step_mode     (step_mode),
    .step_btn      (step_btn),
`endif
    .mrst          (mrst),
    .crst          (crst),
    .cpu_ce        (cpu_ce),
    .sys_ready     (sys_ready),
    .lock_err      (lock_err),
    .lock_loss_cnt (lock_loss_cnt),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_mrst",      mrst,          1);
    check("rst_crst",      crst,          1);
    check("rst_cpu_ce",    cpu_ce,        0);
    check("rst_sys_ready", sys_ready,     0);
    check("rst_lock_err",  lock_err,      0);
    check("rst_loss_cnt",  lock_loss_cnt, 0);
    check("rst_state",     state_dbg,     0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_mrst(input logic lvl, input int max_cyc);
    for (int i = 0; i < max_cyc && mrst !== lvl; i++) tick();
    check("wait_mrst", mrst, lvl);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks     = 0;
    n_pass       = 0;
    cyc          = 0;
    rst          = 1'b1;
    cclk_locked  = 1'b0;
    mclk_locked  = 1'b0;
    soft_rst_req = 1'b0;
    halt_req     = 1'b0;
`ifdef CPU_STEP_EN
    step_mode    = 1'b0;
    step_btn     = 1'b0;
`endif

    // ---- power-up: locks rise at cyc 0 ----
    do_reset();
    cclk_locked = 1'b1;
    mclk_locked = 1'b1;
    // {mrst, crst, sys_ready, cpu_ce} after edges 1..15
    for (int k = 1; k <= 15; k++) begin
      if (k <= 9)       exp_q.push_back(4'b1100);
      else if (k <= 13) exp_q.push_back(4'b0100);
      else              exp_q.push_back(4'b0011);
    end
    for (int k = 1; k <= 15; k++) begin
      logic [3:0] e;
      tick();
      e = exp_q.pop_front();
      check("pwrup_seq", {mrst, crst, sys_ready, cpu_ce}, e);
    end
    check("pwrup_state_run", state_dbg, 2);

    // ---- RST mid-operation ----
    rst = 1'b1;
    tick();
    check("midrst_mrst",  mrst,      1);
    check("midrst_crst",  crst,      1);
    check("midrst_ready", sys_ready, 0);
    check("midrst_state", state_dbg, 0);

    // ---- lock glitch in WAIT_LOCK at count 5 ----
    do_reset();
    run_to(5);
    mclk_locked = 1'b0;
    tick();
    mclk_locked = 1'b1;
    run_to(15);
    check("glitch_mrst_hold", mrst, 1);
    tick();
    check("glitch_mrst_rel", mrst, 0);
    run_to(19);
    check("glitch_crst_hold", crst, 1);
    tick();
    check("glitch_crst_rel",  crst,          0);
    check("glitch_ready",     sys_ready,     1);
    check("glitch_lock_err",  lock_err,      0);
    check("glitch_loss_cnt",  lock_loss_cnt, 0);

    // ---- lock loss in RUN (cclk drops at cyc 22) ----
    run_to(22);
    cclk_locked = 1'b0;
    run_to(24);
    check("loss_still_ready", sys_ready, 1);
    tick();
    check("loss_mrst",     mrst,          1);
    check("loss_crst",     crst,          1);
    check("loss_ready",    sys_ready,     0);
    check("loss_cpu_ce",   cpu_ce,        0);
    check("loss_lock_err", lock_err,      1);
    check("loss_cnt",      lock_loss_cnt, 1);
    check("loss_state",    state_dbg,     4);
    cclk_locked = 1'b1;
    tick();
    check("loss_to_wait", state_dbg, 0);
    run_to(34);
    check("rerel_mrst_hold", mrst, 1);
    tick();
    check("rerel_mrst", mrst, 0);
    run_to(38);
    check("rerel_crst_hold", crst, 1);
    tick();
    check("rerel_crst",     crst,          0);
    check("rerel_ready",    sys_ready,     1);
    check("rerel_lock_err", lock_err,      1);
    check("rerel_cnt",      lock_loss_cnt, 1);

    // ---- soft reset at cyc 41, second request inside SOFT ----
    run_to(41);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("soft_crst",   crst,      1);
    check("soft_mrst",   mrst,      0);
    check("soft_cpu_ce", cpu_ce,    0);
    check("soft_ready",  sys_ready, 0);
    check("soft_state",  state_dbg, 3);
    run_to(43);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("soft_mrst_mid", mrst, 0);
    run_to(45);
    check("soft_crst_last", crst, 1);
    tick();
    check("soft_crst_end", crst,      0);
    check("soft_ready_end", sys_ready, 1);
    check("soft_ce_end",   cpu_ce,    1);
    tick();
    check("soft_no_retrig", crst, 0);

    // ---- halt in RUN ----
    run_to(48);
    halt_req = 1'b1;
    tick();
    check("halt_cpu_ce", cpu_ce,    0);
    check("halt_ready",  sys_ready, 1);
    check("halt_crst",   crst,      0);
    halt_req = 1'b0;
    tick();
    check("unhalt_cpu_ce", cpu_ce, 1);

    // ---- soft request in the same cycle lock_ok drops ----
    run_to(50);
    cclk_locked = 1'b0;
    run_to(52);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("simul_mrst",  mrst,          1);
    check("simul_state", state_dbg,     4);
    check("simul_cnt",   lock_loss_cnt, 2);
    cclk_locked = 1'b1;

    // ---- 300 lock-loss events saturate the counter ----
    do_reset();
    for (int i = 0; i < 300; i++) begin
      wait_mrst(1'b0, 40);
      cclk_locked = 1'b0;
      tick();
      cclk_locked = 1'b1;
      wait_mrst(1'b1, 10);
      if (i == 0) check("sat_first", lock_loss_cnt, 1);
    end
    check("sat_cnt",      lock_loss_cnt, 255);
    check("sat_lock_err", lock_err,      1);

`ifdef CPU_STEP_EN
    // ---- single step: 3 button edges -> 3 one-cycle cpu_ce pulses ----
    begin
      int pulses;
      int longest;
      int run_len;
      do_reset();
      wait_mrst(1'b0, 40);
      repeat (5) tick();
      check("step_ready", sys_ready, 1);
      step_mode = 1'b1;
      tick();
      tick();
      check("step_idle_ce", cpu_ce, 0);
      pulses  = 0;
      longest = 0;
      run_len = 0;
      for (int p = 0; p < 3; p++) begin
        for (int t = 0; t < 10; t++) begin
          step_btn = (t < 5);
          tick();
          if (cpu_ce) begin
            if (run_len == 0) pulses++;
            run_len++;
            if (run_len > longest) longest = run_len;
          end else begin
            run_len = 0;
          end
        end
      end
      repeat (5) begin
        tick();
        if (cpu_ce) pulses++;
      end
      check("step_pulses",  pulses,  3);
      check("step_pulse_w", longest, 1);
      step_mode = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
